// File: rtl/cl_nvdla_pkg.sv
// Shared types and constants for the CL configuration-bus blocks.
// Holds the AXI response codes and the cfg-bus initiator FSM encoding.
package cl_nvdla_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_WR_RSP = 3'd3,
        ST_RD_RSP = 3'd4,
        ST_GAP    = 3'd5
    } cfg_init_state_e;

endpackage

// File: rtl/cl_cfg_axil_initiator.sv
// AXI4-Lite slave to cfg_bus initiator: one access at a time, every request terminated,
// with a timeout so a silent register target cannot stall the host.
module cl_cfg_axil_initiator
    import cl_nvdla_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          TIMEOUT_CYC = 256,
    parameter logic [31:0] TO_RDATA    = 32'hDEAD_DEAD
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,

    output logic [31:0]         cfg_addr,
    output logic [31:0]         cfg_wdata,
    output logic                cfg_wr,
    output logic                cfg_rd,
    input  logic                cfg_ack,
    input  logic [31:0]         cfg_rdata
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    cfg_init_state_e   state, state_nxt;

    logic              accept_en;
    logic              aw_held, w_held;
    logic              last_wr;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [CNT_W-1:0]  to_cnt;

    logic              aw_fire, w_fire, ar_fire;
    logic              wr_go, rd_go, req_ack, req_to;
    logic              wstrb_unused;

    // cfg_bus is full-word only; strobes are accepted and dropped.
    assign wstrb_unused = ^s_wstrb;

    // accept_en keeps all readies low during and for one cycle after reset.
    assign s_awready = accept_en && (state == ST_IDLE) && !aw_held;
    assign s_wready  = accept_en && (state == ST_IDLE) && !w_held;
    // A read may start only with no partial write held; on a tie with a fresh
    // write the side served last yields.
    assign s_arready = accept_en && (state == ST_IDLE) && !aw_held && !w_held &&
                       (!(s_awvalid && s_wvalid) || last_wr);

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid  && s_wready;
    assign ar_fire = s_arvalid && s_arready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        req_ack   = 1'b0;
        req_to    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ar_fire) begin
                    rd_go     = 1'b1;
                    state_nxt = ST_RD_REQ;
                end else if ((aw_held || aw_fire) && (w_held || w_fire)) begin
                    wr_go     = 1'b1;
                    state_nxt = ST_WR_REQ;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                // An ack on the final timeout cycle still completes normally.
                req_ack = cfg_ack;
                req_to  = !cfg_ack && (to_cnt == CNT_LAST);
                if (req_ack || req_to) begin
                    state_nxt = (state == ST_WR_REQ) ? ST_WR_RSP : ST_RD_RSP;
                end
            end
            ST_WR_RSP: if (s_bready) state_nxt = ST_GAP;
            ST_RD_RSP: if (s_rready) state_nxt = ST_GAP;
            ST_GAP:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the capture registers are reset too; the visible payload
            // outputs must read zero out of reset and the flops are few.
            accept_en <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            last_wr   <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            to_cnt    <= '0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            cfg_wr    <= 1'b0;
            cfg_rd    <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
            s_rvalid  <= 1'b0;
            s_rresp   <= RESP_OKAY;
            s_rdata   <= '0;
        end else begin
            accept_en <= 1'b1;

            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_wdata;
            end

            if (wr_go) begin
                cfg_addr  <= 32'(aw_held ? aw_addr_q : s_awaddr);
                cfg_wdata <= 32'(w_held ? w_data_q : s_wdata);
                cfg_wr    <= 1'b1;
                aw_held   <= 1'b0;
                w_held    <= 1'b0;
                last_wr   <= 1'b1;
                to_cnt    <= '0;
            end
            if (rd_go) begin
                cfg_addr <= 32'(s_araddr);
                cfg_rd   <= 1'b1;
                last_wr  <= 1'b0;
                to_cnt   <= '0;
            end

            if ((state == ST_WR_REQ || state == ST_RD_REQ) && !(req_ack || req_to)) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end

            if (req_ack || req_to) begin
                cfg_wr <= 1'b0;
                cfg_rd <= 1'b0;
                if (state == ST_WR_REQ) begin
                    s_bvalid <= 1'b1;
                    s_bresp  <= req_ack ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    s_rvalid <= 1'b1;
                    s_rresp  <= req_ack ? RESP_OKAY : RESP_SLVERR;
                    s_rdata  <= req_ack ? DATA_W'(cfg_rdata) : DATA_W'(TO_RDATA);
                end
            end

            if (state == ST_WR_RSP && s_bready) s_bvalid <= 1'b0;
            if (state == ST_RD_RSP && s_rready) s_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cl_cfg_axil_initiator.sv
// Self-checking bench for cl_cfg_axil_initiator: AXI-Lite master, cfg_bus target model,
// and scoreboards for cfg requests and AXI responses.
module tb_cl_cfg_axil_initiator;
    import cl_nvdla_pkg::*;

    localparam int TO = 8;

    logic        clk, rst;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
    logic        cfg_wr, cfg_rd, cfg_ack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
    } cfg_exp_t;

    typedef struct {
        bit          wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } rsp_exp_t;

    cfg_exp_t cfg_q[$];
    rsp_exp_t rsp_q[$];

    cl_cfg_axil_initiator #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .TIMEOUT_CYC(TO),
        .TO_RDATA   (32'hDEAD_DEAD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_awaddr (s_awaddr),
        .s_awvalid(s_awvalid),
        .s_awready(s_awready),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wvalid (s_wvalid),
        .s_wready (s_wready),
        .s_bresp  (s_bresp),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_araddr (s_araddr),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_rdata  (s_rdata),
        .s_rresp  (s_rresp),
        .s_rvalid (s_rvalid),
        .s_rready (s_rready),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_wr   (cfg_wr),
        .cfg_rd   (cfg_rd),
        .cfg_ack  (cfg_ack),
        .cfg_rdata(cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register target: acks ack_lat cycles after the request rises.
    int          ack_lat    = 2;
    bit          ack_en     = 1'b1;
    bit          stray_ack  = 1'b0;
    logic [31:0] tgt_rdata  = 32'h0;
    int          tcnt       = 0;

    always @(posedge clk) begin
        #1;
        if (stray_ack) begin
            cfg_ack   = 1'b1;
            cfg_rdata = 32'hBAD0_BAD0;
            stray_ack = 1'b0;
            tcnt      = 0;
        end else if ((cfg_wr || cfg_rd) && ack_en) begin
            tcnt++;
            cfg_ack   = (tcnt == ack_lat);
            cfg_rdata = cfg_ack ? tgt_rdata : $urandom;
        end else begin
            tcnt      = 0;
            cfg_ack   = 1'b0;
            cfg_rdata = $urandom;
        end
    end

    // cfg request scoreboard: order, type, address, data, hold length, idle gap.
    bit          prev_req = 1'b0;
    bit          have_cur = 1'b0;
    bit          seen_any = 1'b0;
    int          hold_cnt = 0;
    int          low_cnt  = 0;
    cfg_exp_t    cur;
    logic [31:0] hold_addr, hold_wdata;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            have_cur = 1'b0;
            seen_any = 1'b0;
            hold_cnt = 0;
            low_cnt  = 0;
        end else begin
            if (cfg_wr && cfg_rd) begin
                checks++;
                errors++;
                $display("FAIL cfg_both_req got wr=1 rd=1 want at most one");
            end
            if ((cfg_wr || cfg_rd) && !prev_req) begin
                if (seen_any) begin
                    checks++;
                    if (low_cnt < 3) begin
                        errors++;
                        $display("FAIL cfg_gap got %0d idle cycles want >= 3", low_cnt);
                    end
                end
                checks++;
                if (cfg_q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg_unexpected got wr=%0b addr=%h want no request", cfg_wr, cfg_addr);
                end else begin
                    cur = cfg_q.pop_front();
                    have_cur = 1'b1;
                    if (cfg_wr !== cur.wr || cfg_addr !== cur.addr ||
                        (cur.wr && cfg_wdata !== cur.wdata)) begin
                        errors++;
                        $display("FAIL cfg_req got wr=%0b addr=%h wdata=%h want wr=%0b addr=%h wdata=%h",
                                 cfg_wr, cfg_addr, cfg_wdata, cur.wr, cur.addr, cur.wdata);
                    end
                end
                seen_any   = 1'b1;
                hold_cnt   = 1;
                hold_addr  = cfg_addr;
                hold_wdata = cfg_wdata;
            end else if (cfg_wr || cfg_rd) begin
                hold_cnt++;
                if (cfg_addr !== hold_addr || cfg_wdata !== hold_wdata) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg_stable got addr=%h wdata=%h want addr=%h wdata=%h",
                             cfg_addr, cfg_wdata, hold_addr, hold_wdata);
                end
            end else if (prev_req) begin
                if (have_cur && cur.hold >= 0) begin
                    checks++;
                    if (hold_cnt != cur.hold) begin
                        errors++;
                        $display("FAIL cfg_hold got %0d cycles want %0d", hold_cnt, cur.hold);
                    end
                end
                have_cur = 1'b0;
                low_cnt  = 1;
            end else begin
                low_cnt++;
            end
            prev_req = cfg_wr || cfg_rd;
        end
    end

    // AXI response scoreboard, compared at each B/R handshake.
    rsp_exp_t b_exp, r_exp;

    always @(negedge clk) begin
        if (!rst) begin
            if (s_bvalid && s_bready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected got bresp=%b want no response", s_bresp);
                end else begin
                    b_exp = rsp_q.pop_front();
                    if (!b_exp.wr || s_bresp !== b_exp.resp) begin
                        errors++;
                        $display("FAIL b_resp got write bresp=%b want wr=%0b resp=%b",
                                 s_bresp, b_exp.wr, b_exp.resp);
                    end
                end
            end
            if (s_rvalid && s_rready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected got rresp=%b rdata=%h want no response", s_rresp, s_rdata);
                end else begin
                    r_exp = rsp_q.pop_front();
                    if (r_exp.wr || s_rresp !== r_exp.resp || s_rdata !== r_exp.rdata) begin
                        errors++;
                        $display("FAIL r_resp got read rresp=%b rdata=%h want wr=%0b resp=%b rdata=%h",
                                 s_rresp, s_rdata, r_exp.wr, r_exp.resp, r_exp.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic push_cfg(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        cfg_exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.hold = hold;
        cfg_q.push_back(e);
    endtask

    task automatic push_rsp(input bit wr, input logic [1:0] resp, input logic [31:0] rdata);
        rsp_exp_t e;
        e.wr = wr; e.resp = resp; e.rdata = rdata;
        rsp_q.push_back(e);
    endtask

    // Raise the selected valids together and hold each until its handshake.
    task automatic axi_send(input bit do_aw, input bit do_w, input bit do_ar,
                            input logic [31:0] awaddr, input logic [31:0] wdata,
                            input logic [31:0] araddr);
        bit a, w, r;
        int n = 0;
        @(posedge clk); #1;
        if (do_aw) begin s_awaddr = awaddr; s_awvalid = 1'b1; end
        if (do_w)  begin s_wdata = wdata; s_wstrb = 4'hF; s_wvalid = 1'b1; end
        if (do_ar) begin s_araddr = araddr; s_arvalid = 1'b1; end
        while ((s_awvalid || s_wvalid || s_arvalid) && n < 60) begin
            @(negedge clk);
            a = s_awvalid && s_awready;
            w = s_wvalid && s_wready;
            r = s_arvalid && s_arready;
            @(posedge clk); #1;
            if (a) s_awvalid = 1'b0;
            if (w) s_wvalid = 1'b0;
            if (r) s_arvalid = 1'b0;
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL handshake got aw=%0b w=%0b ar=%0b pending want all accepted",
                     s_awvalid, s_wvalid, s_arvalid);
            s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((rsp_q.size() != 0 || cfg_wr || cfg_rd || s_bvalid || s_rvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_done got %0d responses pending want 0", name, rsp_q.size());
            rsp_q.delete();
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cfg_q.size() != 0) begin
            errors++;
            $display("FAIL %s_cfg_issued got %0d requests missing want 0", name, cfg_q.size());
            cfg_q.delete();
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rsp_q.delete();
        cfg_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cfg_wr, cfg_rd} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000000",
                     {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cfg_wr, cfg_rd});
        end
        checks++;
        if ({s_bresp, s_rresp} !== 4'b0 || s_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp got bresp=%b rresp=%b rdata=%h want 0", s_bresp, s_rresp, s_rdata);
        end
        checks++;
        if (cfg_addr !== 32'h0 || cfg_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_cfg got addr=%h wdata=%h want 0", cfg_addr, cfg_wdata);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL idle_ready got %b want 111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_write_same_cycle();
        ack_lat = 3;
        push_cfg(1'b1, 32'h10, 32'hCAFE_0001, 3);
        push_rsp(1'b1, RESP_OKAY, 32'h0);
        axi_send(1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFE_0001, 32'h0);
        wait_done("write_same_cycle");
    endtask

    task automatic test_w_before_aw();
        bit saw = 1'b0;
        ack_lat = 2;
        push_cfg(1'b1, 32'h24, 32'h5555_AAAA, 2);
        push_rsp(1'b1, RESP_OKAY, 32'h0);
        axi_send(1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_AAAA, 32'h0);
        repeat (4) begin
            @(negedge clk);
            if (cfg_wr || cfg_rd) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL w_only_no_req got request=1 want 0");
        end
        axi_send(1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 32'h0);
        wait_done("w_before_aw");
    endtask

    task automatic test_read_backpressure();
        int n = 0;
        ack_lat   = 2;
        tgt_rdata = 32'h1234_5678;
        s_rready  = 1'b0;
        push_cfg(1'b0, 32'h40, 32'h0, 2);
        push_rsp(1'b0, RESP_OKAY, 32'h1234_5678);
        axi_send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h40);
        while (!s_rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_rvalid) begin
            errors++;
            $display("FAIL rd_bp_rvalid got 0 want 1");
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({s_rvalid, s_rresp, s_rdata, cfg_rd, cfg_wr} !== {1'b1, RESP_OKAY, 32'h1234_5678, 2'b00}) begin
                errors++;
                $display("FAIL rd_bp_hold got rvalid=%0b rresp=%b rdata=%h req=%0b want 1 00 12345678 0",
                         s_rvalid, s_rresp, s_rdata, cfg_rd | cfg_wr);
            end
        end
        @(posedge clk); #1 s_rready = 1'b1;
        wait_done("read_backpressure");
    endtask

    task automatic test_timeouts();
        int n = 0;
        bit saw = 1'b0;
        ack_en = 1'b0;
        push_cfg(1'b0, 32'h50, 32'h0, TO);
        push_rsp(1'b0, RESP_SLVERR, 32'hDEAD_DEAD);
        axi_send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h50);
        wait_done("read_timeout");

        push_cfg(1'b1, 32'h54, 32'h1111_2222, TO);
        push_rsp(1'b1, RESP_SLVERR, 32'h0);
        axi_send(1'b1, 1'b1, 1'b0, 32'h54, 32'h1111_2222, 32'h0);
        while (!s_bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        stray_ack = 1'b1;
        wait_done("write_timeout");

        @(negedge clk) stray_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (s_bvalid || s_rvalid || cfg_wr || cfg_rd) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack got activity=1 want 0");
        end

        ack_en    = 1'b1;
        ack_lat   = 2;
        tgt_rdata = 32'h600D_0001;
        push_cfg(1'b0, 32'h58, 32'h0, 2);
        push_rsp(1'b0, RESP_OKAY, 32'h600D_0001);
        axi_send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h58);
        wait_done("after_stray");

        ack_lat   = TO;
        tgt_rdata = 32'hA5A5_0008;
        push_cfg(1'b0, 32'h5C, 32'h0, TO);
        push_rsp(1'b0, RESP_OKAY, 32'hA5A5_0008);
        axi_send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h5C);
        wait_done("read_ack_at_timeout");
        push_cfg(1'b1, 32'h60, 32'h0808_0808, TO);
        push_rsp(1'b1, RESP_OKAY, 32'h0);
        axi_send(1'b1, 1'b1, 1'b0, 32'h60, 32'h0808_0808, 32'h0);
        wait_done("write_ack_at_timeout");
    endtask

    task automatic test_contention();
        apply_reset();
        ack_lat   = 1;
        tgt_rdata = 32'h0000_0200;
        push_cfg(1'b1, 32'h100, 32'hAAAA_0001, 1);
        push_rsp(1'b1, RESP_OKAY, 32'h0);
        push_cfg(1'b0, 32'h200, 32'h0, 1);
        push_rsp(1'b0, RESP_OKAY, 32'h0000_0200);
        axi_send(1'b1, 1'b1, 1'b1, 32'h100, 32'hAAAA_0001, 32'h200);
        wait_done("contention_1");
        push_cfg(1'b1, 32'h104, 32'hAAAA_0002, 1);
        push_rsp(1'b1, RESP_OKAY, 32'h0);
        push_cfg(1'b0, 32'h204, 32'h0, 1);
        push_rsp(1'b0, RESP_OKAY, 32'h0000_0200);
        axi_send(1'b1, 1'b1, 1'b1, 32'h104, 32'hAAAA_0002, 32'h204);
        wait_done("contention_2");
    endtask

    task automatic test_reset_mid_access();
        int n = 0;
        bit saw = 1'b0;
        ack_en = 1'b0;
        push_cfg(1'b0, 32'h80, 32'h0, -1);
        axi_send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h80);
        while (!cfg_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cfg_rd !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_req got cfg_rd=%0b want 1", cfg_rd);
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        checks++;
        if (cfg_rd !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_async got cfg_rd=%0b want 0", cfg_rd);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rsp_q.delete();
        cfg_q.delete();
        @(negedge clk) stray_ack = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (s_rvalid || s_bvalid || cfg_rd || cfg_wr) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_quiet got activity=1 want 0");
        end
        ack_en    = 1'b1;
        ack_lat   = 2;
        tgt_rdata = 32'h7777_0084;
        push_cfg(1'b0, 32'h84, 32'h0, 2);
        push_rsp(1'b0, RESP_OKAY, 32'h7777_0084);
        axi_send(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h84);
        wait_done("after_reset_read");
    endtask

    initial begin
        rst       = 1'b1;
        s_awaddr  = '0; s_awvalid = 1'b0;
        s_wdata   = '0; s_wstrb   = '0; s_wvalid = 1'b0;
        s_araddr  = '0; s_arvalid = 1'b0;
        s_bready  = 1'b1;
        s_rready  = 1'b1;
        cfg_ack   = 1'b0;
        cfg_rdata = '0;
        repeat (2) @(posedge clk);

        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_backpressure();
        test_timeouts();
        test_contention();
        test_reset_mid_access();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
